// File: rtl/vga_hex_renderer.sv
// Pixel stage behind the VGA scanner: draws a 16-bit word as four scaled hex
// glyphs inside a fixed box, with hs/vs delayed to match the 2-cycle RGB pipe.
module vga_hex_renderer #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         X0          = 64,
    parameter int         Y0          = 32,
    parameter int         SCALE_SHIFT = 2,
    parameter logic [8:0] FG          = 9'b111_111_111,
    parameter logic [8:0] BG          = 9'b000_000_100,
    parameter logic [8:0] SCREEN      = 9'b000_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [15:0] value,
    input  logic        freeze,
    output logic        hs,
    output logic        vs,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [2:0]  b
);

    localparam int         BOX_W  = 32 << SCALE_SHIFT;
    localparam int         BOX_H  = 8 << SCALE_SHIFT;
    localparam logic [11:0] L_HACT = 12'(H_ACTIVE);
    localparam logic [11:0] L_VACT = 12'(V_ACTIVE);
    localparam logic [11:0] L_X0   = 12'(X0);
    localparam logic [11:0] L_Y0   = 12'(Y0);
    localparam logic [11:0] L_X1   = 12'(X0 + BOX_W);
    localparam logic [11:0] L_Y1   = 12'(Y0 + BOX_H);

    function automatic logic [63:0] glyph(input logic [3:0] n);
        logic [63:0] v;
        case (n)
            4'h0:    v = 64'h3C666E7666663C00;
            4'h1:    v = 64'h1838181818187E00;
            4'h2:    v = 64'h3C66060C30607E00;
            4'h3:    v = 64'h3C66061C06663C00;
            4'h4:    v = 64'h0C1C3C6C7E0C0C00;
            4'h5:    v = 64'h7E607C0606663C00;
            4'h6:    v = 64'h3C66607C66663C00;
            4'h7:    v = 64'h7E660C1818181800;
            4'h8:    v = 64'h3C66663C66663C00;
            4'h9:    v = 64'h3C66663E06663C00;
            4'hA:    v = 64'h183C667E66666600;
            4'hB:    v = 64'h7C66667C66667C00;
            4'hC:    v = 64'h3C66606060663C00;
            4'hD:    v = 64'h786C6666666C7800;
            4'hE:    v = 64'h7E60607860607E00;
            default: v = 64'h7E60607C60606000;
        endcase
        return v;
    endfunction

    logic [15:0] r_shadow;
    logic        r_vs_prev;

    logic        r_act1;
    logic        r_inbox1;
    logic [2:0]  r_col1;
    logic [2:0]  r_row1;
    logic [3:0]  r_nib1;
    logic        r_hs1;
    logic        r_vs1;

    logic [8:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;

    logic        w_act;
    logic        w_inbox;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [1:0]  w_digit;
    logic [2:0]  w_col;
    logic [2:0]  w_row;
    logic [3:0]  w_nib;
    logic [63:0] w_glyph;
    logic [7:0]  w_bits;
    logic        w_pix;
    logic [8:0]  w_rgb;

    // Widen to 12 bits so box limits past 2047 cannot wrap.
    always_comb begin
        w_act   = ({1'b0, x} < L_HACT) && ({1'b0, y} < L_VACT);
        w_inbox = w_act
                  && ({1'b0, x} >= L_X0) && ({1'b0, x} < L_X1)
                  && ({1'b0, y} >= L_Y0) && ({1'b0, y} < L_Y1);
        w_dx    = x - 11'(X0);
        w_dy    = y - 11'(Y0);
        w_digit = 2'(w_dx >> (3 + SCALE_SHIFT));
        w_col   = 3'(w_dx >> SCALE_SHIFT);
        w_row   = 3'(w_dy >> SCALE_SHIFT);
    end

    always_comb begin
        w_nib = r_shadow[3:0];
        case (w_digit)
            2'd0:    w_nib = r_shadow[15:12];
            2'd1:    w_nib = r_shadow[11:8];
            2'd2:    w_nib = r_shadow[7:4];
            default: w_nib = r_shadow[3:0];
        endcase
    end

    always_comb begin
        w_glyph = glyph(r_nib1);
        w_bits  = w_glyph[8*(7 - r_row1) +: 8];
        w_pix   = w_bits[3'd7 - r_col1];
        w_rgb   = 9'd0;
        if (r_inbox1)
            w_rgb = w_pix ? FG : BG;
        else if (r_act1)
            w_rgb = SCREEN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= 16'h0000;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_prev <= vs_in;
            if (r_vs_prev && !vs_in && !freeze)
                r_shadow <= value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act1   <= 1'b0;
            r_inbox1 <= 1'b0;
            r_col1   <= 3'd0;
            r_row1   <= 3'd0;
            r_nib1   <= 4'd0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_rgb    <= 9'd0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
        end else begin
            r_act1   <= w_act;
            r_inbox1 <= w_inbox;
            r_col1   <= w_col;
            r_row1   <= w_row;
            r_nib1   <= w_nib;
            r_hs1    <= hs_in;
            r_vs1    <= vs_in;
            r_rgb    <= w_rgb;
            r_hs     <= r_hs1;
            r_vs     <= r_vs1;
        end
    end

    assign hs = r_hs;
    assign vs = r_vs;
    assign r  = r_rgb[8:6];
    assign g  = r_rgb[5:3];
    assign b  = r_rgb[2:0];

endmodule
